// File: rtl/hammu_pow_axi_if.sv
// AXI4-Lite bus bundle for the hammu_pow_axi peripheral.
// The peripheral connects through the slave modport and the bus driver through the master modport.
interface hammu_pow_axi_if;
  logic [31:0] S_AXI_AWADDR;
  logic        S_AXI_AWVALID;
  logic        S_AXI_AWREADY;
  logic [31:0] S_AXI_WDATA;
  logic [3:0]  S_AXI_WSTRB;
  logic        S_AXI_WVALID;
  logic        S_AXI_WREADY;
  logic [1:0]  S_AXI_BRESP;
  logic        S_AXI_BVALID;
  logic        S_AXI_BREADY;
  logic [31:0] S_AXI_ARADDR;
  logic        S_AXI_ARVALID;
  logic        S_AXI_ARREADY;
  logic [31:0] S_AXI_RDATA;
  logic [1:0]  S_AXI_RRESP;
  logic        S_AXI_RVALID;
  logic        S_AXI_RREADY;

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID, S_AXI_BREADY,
           S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
    output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID, S_AXI_ARREADY,
           S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );

  modport master (
    output S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID, S_AXI_BREADY,
           S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
    input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID, S_AXI_ARREADY,
           S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );
endinterface

// File: rtl/hammu_pow_axi.sv
// AXI4-Lite peripheral computing P = X^A by right-to-left square-and-multiply.
// The engine always runs EXP_W iterations, so its latency does not depend on the operands.
module hammu_pow_axi #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned EXP_W  = 8,
  parameter int unsigned ADDR_W = 5
) (
  input  logic           S_AXI_ACLK,
  input  logic           S_AXI_ARESET,
  hammu_pow_axi_if.slave s_axi,
  output logic           IRQ
);

  localparam int unsigned CntW = (EXP_W > 1) ? $clog2(EXP_W) : 1;
  localparam logic [ADDR_W-1:0] OffX      = ADDR_W'(32'h00);
  localparam logic [ADDR_W-1:0] OffA      = ADDR_W'(32'h04);
  localparam logic [ADDR_W-1:0] OffCtrl   = ADDR_W'(32'h08);
  localparam logic [ADDR_W-1:0] OffP      = ADDR_W'(32'h0C);
  localparam logic [ADDR_W-1:0] OffStatus = ADDR_W'(32'h10);
  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlvErr = 2'b10;

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   base_q, base_d, acc_q, acc_d;
  logic [EXP_W-1:0]    e_q, e_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                base_big_q, base_big_d, ovf_run_q, ovf_run_d, sat_run_q, sat_run_d;
  logic [2*DATA_W-1:0] prod_acc, prod_base;
  logic [DATA_W-1:0]   p_res;
  logic                finish;

  logic [DATA_W-1:0] x_q, p_q;
  logic [EXP_W-1:0]  a_q;
  logic              irq_en_q, sat_q, done_q, ovf_q, start_err_q;

  logic        awready_q, bvalid_q, arready_q, rvalid_q;
  logic [1:0]  bresp_q, rresp_q;
  logic [31:0] rdata_q, rd_data, wdata;
  logic [ADDR_W-1:0] wr_addr, rd_addr;
  logic        wr_hs, rd_hs, wr_err, rd_err, wr_ctrl, wr_status;
  logic        busy, start_req, start_ok, start_err_set;
  logic        unused_bits;

  assign wdata     = s_axi.S_AXI_WDATA;
  assign wr_addr   = s_axi.S_AXI_AWADDR[ADDR_W-1:0];
  assign rd_addr   = s_axi.S_AXI_ARADDR[ADDR_W-1:0];
  assign wr_hs     = awready_q & s_axi.S_AXI_AWVALID & s_axi.S_AXI_WVALID;
  assign rd_hs     = arready_q & s_axi.S_AXI_ARVALID;
  assign wr_ctrl   = wr_hs & (wr_addr == OffCtrl);
  assign wr_status = wr_hs & (wr_addr == OffStatus);
  assign wr_err    = !(wr_addr inside {OffX, OffA, OffCtrl, OffP, OffStatus});
  assign busy      = (state_q == StRun);
  assign start_req = wr_ctrl & wdata[0];
  assign start_ok  = start_req & ~busy;
  assign start_err_set = start_req & busy;
  assign IRQ       = done_q & irq_en_q;
  assign unused_bits = ^{s_axi.S_AXI_WSTRB, s_axi.S_AXI_AWADDR, s_axi.S_AXI_ARADDR, wdata};

  assign s_axi.S_AXI_AWREADY = awready_q;
  assign s_axi.S_AXI_WREADY  = awready_q;
  assign s_axi.S_AXI_BVALID  = bvalid_q;
  assign s_axi.S_AXI_BRESP   = bresp_q;
  assign s_axi.S_AXI_ARREADY = arready_q;
  assign s_axi.S_AXI_RVALID  = rvalid_q;
  assign s_axi.S_AXI_RDATA   = rdata_q;
  assign s_axi.S_AXI_RRESP   = rresp_q;

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    e_d        = e_q;
    acc_d      = acc_q;
    base_big_d = base_big_q;
    ovf_run_d  = ovf_run_q;
    cnt_d      = cnt_q;
    sat_run_d  = sat_run_q;
    finish     = 1'b0;
    prod_acc   = {{DATA_W{1'b0}}, acc_q} * {{DATA_W{1'b0}}, base_q};
    prod_base  = {{DATA_W{1'b0}}, base_q} * {{DATA_W{1'b0}}, base_q};
    case (state_q)
      StIdle: begin
        if (start_req) begin
          state_d    = StRun;
          base_d     = x_q;
          e_d        = a_q;
          acc_d      = DATA_W'(1);
          base_big_d = 1'b0;
          ovf_run_d  = 1'b0;
          cnt_d      = '0;
          sat_run_d  = wdata[2];
        end
      end
      StRun: begin
        // A base that already outgrew DATA_W poisons any product it joins.
        if (e_q[0]) begin
          acc_d     = prod_acc[DATA_W-1:0];
          ovf_run_d = ovf_run_q | base_big_q | (|prod_acc[2*DATA_W-1:DATA_W]);
        end
        base_d     = prod_base[DATA_W-1:0];
        base_big_d = base_big_q | (|prod_base[2*DATA_W-1:DATA_W]);
        e_d        = e_q >> 1;
        cnt_d      = cnt_q + 1'b1;
        if (cnt_q == CntW'(EXP_W - 1)) begin
          state_d = StIdle;
          finish  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    p_res = (sat_run_q & ovf_run_d) ? '1 : acc_d;
  end

  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      state_q    <= StIdle;
      base_q     <= '0;
      e_q        <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      base_big_q <= 1'b0;
      ovf_run_q  <= 1'b0;
      sat_run_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      e_q        <= e_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      base_big_q <= base_big_d;
      ovf_run_q  <= ovf_run_d;
      sat_run_q  <= sat_run_d;
    end
  end

  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      x_q         <= '0;
      a_q         <= '0;
      p_q         <= '0;
      irq_en_q    <= 1'b0;
      sat_q       <= 1'b0;
      done_q      <= 1'b0;
      ovf_q       <= 1'b0;
      start_err_q <= 1'b0;
    end else begin
      if (wr_hs) begin
        case (wr_addr)
          OffX:    x_q <= wdata[DATA_W-1:0];
          OffA:    a_q <= wdata[EXP_W-1:0];
          OffCtrl: begin
            irq_en_q <= wdata[1];
            sat_q    <= wdata[2];
          end
          default: ;
        endcase
      end
      // Completion outranks a same-edge DONE clear.
      if (finish) begin
        done_q <= 1'b1;
        ovf_q  <= ovf_run_d;
        p_q    <= p_res;
      end else if (start_ok) begin
        done_q <= 1'b0;
        ovf_q  <= 1'b0;
      end else if (wr_status & wdata[0]) begin
        done_q <= 1'b0;
      end
      if (start_err_set) begin
        start_err_q <= 1'b1;
      end else if (wr_status & wdata[3]) begin
        start_err_q <= 1'b0;
      end
    end
  end

  always_comb begin
    rd_data = '0;
    rd_err  = 1'b0;
    case (rd_addr)
      OffX:      rd_data = 32'(x_q);
      OffA:      rd_data = 32'(a_q);
      OffCtrl:   rd_data = {29'b0, sat_q, irq_en_q, 1'b0};
      OffP:      rd_data = 32'(p_q);
      OffStatus: rd_data = {28'b0, start_err_q, ovf_q, busy, done_q};
      default:   rd_err  = 1'b1;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      awready_q <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RespOkay;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RespOkay;
    end else begin
      awready_q <= ~awready_q & s_axi.S_AXI_AWVALID & s_axi.S_AXI_WVALID & ~bvalid_q;
      if (wr_hs) begin
        bvalid_q <= 1'b1;
        bresp_q  <= wr_err ? RespSlvErr : RespOkay;
      end else if (s_axi.S_AXI_BREADY) begin
        bvalid_q <= 1'b0;
      end
      arready_q <= ~arready_q & s_axi.S_AXI_ARVALID & ~rvalid_q;
      if (rd_hs) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_data;
        rresp_q  <= rd_err ? RespSlvErr : RespOkay;
      end else if (s_axi.S_AXI_RREADY) begin
        rvalid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_hammu_pow_axi.sv
// Directed bench for hammu_pow_axi: register access, power results, latency, errors, backpressure.
module tb_hammu_pow_axi;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic irq;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   t_hs = 0;

  localparam logic [31:0] Base = 32'h7c80_0000;

  hammu_pow_axi_if bus ();

  hammu_pow_axi #(
    .DATA_W(16),
    .EXP_W (8),
    .ADDR_W(5)
  ) dut (
    .S_AXI_ACLK  (clk),
    .S_AXI_ARESET(rst),
    .s_axi       (bus),
    .IRQ         (irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed=no finish required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic axi_write(input logic [31:0] off, input logic [31:0] data, output logic [1:0] resp);
    int n;
    @(negedge clk);
    bus.S_AXI_AWADDR  = Base + off;
    bus.S_AXI_WDATA   = data;
    bus.S_AXI_AWVALID = 1'b1;
    bus.S_AXI_WVALID  = 1'b1;
    n = 0;
    while (!(bus.S_AXI_AWREADY && bus.S_AXI_WREADY) && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("aw_ready", {31'b0, bus.S_AXI_AWREADY}, 32'd1);
    @(posedge clk);
    #1;
    t_hs = cyc;
    bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WVALID  = 1'b0;
    n = 0;
    while (!bus.S_AXI_BVALID && n < 20) begin
      @(negedge clk);
      n++;
    end
    resp = bus.S_AXI_BRESP;
    @(posedge clk);
    #1;
  endtask

  task automatic axi_read(input logic [31:0] off, output logic [31:0] data, output logic [1:0] resp);
    int n;
    @(negedge clk);
    bus.S_AXI_ARADDR  = Base + off;
    bus.S_AXI_ARVALID = 1'b1;
    n = 0;
    while (!bus.S_AXI_ARREADY && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("ar_ready", {31'b0, bus.S_AXI_ARREADY}, 32'd1);
    @(posedge clk);
    #1;
    bus.S_AXI_ARVALID = 1'b0;
    n = 0;
    while (!bus.S_AXI_RVALID && n < 20) begin
      @(negedge clk);
      n++;
    end
    data = bus.S_AXI_RDATA;
    resp = bus.S_AXI_RRESP;
    @(posedge clk);
    #1;
  endtask

  // Writes operands, starts, checks IRQ timing when enabled, then checks P and STATUS.
  task automatic run(input logic [31:0] x, input logic [31:0] a, input logic [31:0] ctrl,
                     input logic [31:0] exp_p, input logic [31:0] exp_st, input string tag);
    logic [1:0]  r;
    logic [31:0] d;
    int          ts;
    axi_write(32'h00, x, r);
    axi_write(32'h04, a, r);
    axi_write(32'h08, ctrl, r);
    ts = t_hs;
    if (ctrl[1]) begin
      wait_cyc(ts + 7);
      check({tag, "_irq_t7"}, {31'b0, irq}, 32'd0);
      wait_cyc(ts + 8);
      check({tag, "_irq_t8"}, {31'b0, irq}, 32'd1);
    end else begin
      wait_cyc(ts + 8);
    end
    axi_read(32'h0C, d, r);
    check({tag, "_p"}, d, exp_p);
    check({tag, "_rresp"}, {30'b0, r}, 32'd0);
    axi_read(32'h10, d, r);
    check({tag, "_status"}, d, exp_st);
  endtask

  initial begin
    logic [1:0]  r;
    logic [31:0] d;
    int          ts;
    int          n;

    bus.S_AXI_AWADDR = '0; bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WDATA = '0;  bus.S_AXI_WSTRB = 4'hF; bus.S_AXI_WVALID = 1'b0;
    bus.S_AXI_BREADY = 1'b1;
    bus.S_AXI_ARADDR = '0; bus.S_AXI_ARVALID = 1'b0; bus.S_AXI_RREADY = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_awready", {31'b0, bus.S_AXI_AWREADY}, 32'd0);
    check("rst_arready", {31'b0, bus.S_AXI_ARREADY}, 32'd0);
    check("rst_bvalid",  {31'b0, bus.S_AXI_BVALID}, 32'd0);
    check("rst_rvalid",  {31'b0, bus.S_AXI_RVALID}, 32'd0);
    check("rst_rdata",   bus.S_AXI_RDATA, 32'd0);
    check("rst_irq",     {31'b0, irq}, 32'd0);
    rst = 1'b0;
    axi_read(32'h0C, d, r); check("rst_p", d, 32'd0);
    axi_read(32'h10, d, r); check("rst_status", d, 32'd0);

    // Basic 2^3 with BUSY visible mid-run
    axi_write(32'h00, 32'd2, r); check("basic_bresp", {30'b0, r}, 32'd0);
    axi_write(32'h04, 32'd3, r);
    axi_write(32'h08, 32'd1, r);
    ts = t_hs;
    axi_read(32'h10, d, r); check("basic_busy", d, 32'h2);
    wait_cyc(ts + 8);
    axi_read(32'h0C, d, r); check("basic_p", d, 32'd8); check("basic_rresp", {30'b0, r}, 32'd0);
    axi_read(32'h10, d, r); check("basic_status", d, 32'h1);
    axi_read(32'h00, d, r); check("rd_x", d, 32'd2);
    axi_read(32'h04, d, r); check("rd_a", d, 32'd3);
    axi_read(32'h08, d, r); check("rd_ctrl", d, 32'd0);

    // Overflow wrap then saturate
    run(32'd3, 32'd11, 32'h3, 32'hB3FB, 32'h5, "wrap");
    run(32'd3, 32'd11, 32'h7, 32'hFFFF, 32'h5, "sat");
    axi_read(32'h08, d, r); check("rd_ctrl_sat", d, 32'h6);

    // Edge operands, wrap mode
    run(32'd0, 32'd0,   32'h3, 32'd1,     32'h1, "p0_0");
    run(32'd5, 32'd0,   32'h3, 32'd1,     32'h1, "p5_0");
    run(32'd0, 32'd7,   32'h3, 32'd0,     32'h1, "p0_7");
    run(32'd1, 32'd255, 32'h3, 32'd1,     32'h1, "p1_255");
    run(32'd2, 32'd15,  32'h3, 32'h8000,  32'h1, "p2_15");
    run(32'd2, 32'd16,  32'h3, 32'd0,     32'h5, "p2_16");

    // START while busy, then W1C
    axi_write(32'h00, 32'd2, r);
    axi_write(32'h04, 32'd3, r);
    axi_write(32'h08, 32'h3, r);
    ts = t_hs;
    axi_write(32'h08, 32'h3, r);
    wait_cyc(ts + 7); check("busy_irq_t7", {31'b0, irq}, 32'd0);
    wait_cyc(ts + 8); check("busy_irq_t8", {31'b0, irq}, 32'd1);
    axi_read(32'h10, d, r); check("busy_status", d, 32'h9);
    axi_read(32'h0C, d, r); check("busy_p", d, 32'd8);
    axi_write(32'h10, 32'h9, r);
    axi_read(32'h10, d, r); check("w1c_status", d, 32'h0);
    check("w1c_irq", {31'b0, irq}, 32'd0);

    // Bus errors and RO write
    axi_read(32'h14, d, r); check("bad_rresp", {30'b0, r}, 32'h2); check("bad_rdata", d, 32'd0);
    axi_write(32'h14, 32'hFFFF_FFFF, r); check("bad_bresp", {30'b0, r}, 32'h2);
    axi_write(32'h0C, 32'h1234, r); check("ro_bresp", {30'b0, r}, 32'h0);
    axi_read(32'h0C, d, r); check("ro_p", d, 32'd8);

    // Write backpressure: X=9 held in B, second write (A=5) kept pending
    bus.S_AXI_BREADY = 1'b0;
    @(negedge clk);
    bus.S_AXI_AWADDR = Base; bus.S_AXI_WDATA = 32'd9;
    bus.S_AXI_AWVALID = 1'b1; bus.S_AXI_WVALID = 1'b1;
    n = 0;
    while (!bus.S_AXI_AWREADY && n < 20) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    bus.S_AXI_AWADDR = Base + 32'h04; bus.S_AXI_WDATA = 32'd5;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("b_hold_valid", {31'b0, bus.S_AXI_BVALID}, 32'd1);
      check("b_hold_resp", {30'b0, bus.S_AXI_BRESP}, 32'd0);
      check("b_hold_awready", {31'b0, bus.S_AXI_AWREADY}, 32'd0);
    end
    bus.S_AXI_BREADY = 1'b1;
    n = 0;
    while (!bus.S_AXI_AWREADY && n < 20) begin @(negedge clk); n++; end
    check("b_second_aw", {31'b0, bus.S_AXI_AWREADY}, 32'd1);
    @(posedge clk); #1;
    bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Read backpressure: X held in R, second read (A) kept pending
    bus.S_AXI_RREADY = 1'b0;
    @(negedge clk);
    bus.S_AXI_ARADDR = Base; bus.S_AXI_ARVALID = 1'b1;
    n = 0;
    while (!bus.S_AXI_ARREADY && n < 20) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    bus.S_AXI_ARADDR = Base + 32'h04;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("r_hold_valid", {31'b0, bus.S_AXI_RVALID}, 32'd1);
      check("r_hold_data", bus.S_AXI_RDATA, 32'd9);
      check("r_hold_arready", {31'b0, bus.S_AXI_ARREADY}, 32'd0);
    end
    bus.S_AXI_RREADY = 1'b1;
    @(posedge clk); #1;
    n = 0;
    while (!bus.S_AXI_ARREADY && n < 20) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    bus.S_AXI_ARVALID = 1'b0;
    n = 0;
    while (!bus.S_AXI_RVALID && n < 20) begin @(negedge clk); n++; end
    check("r_second_data", bus.S_AXI_RDATA, 32'd5);
    @(posedge clk); #1;

    // Reset mid-run, then a clean run
    axi_write(32'h00, 32'd3, r);
    axi_write(32'h04, 32'd11, r);
    axi_write(32'h08, 32'h3, r);
    ts = t_hs;
    wait_cyc(ts + 4);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_irq", {31'b0, irq}, 32'd0);
    axi_read(32'h0C, d, r); check("mid_rst_p", d, 32'd0);
    axi_read(32'h10, d, r); check("mid_rst_status", d, 32'd0);
    wait_cyc(ts + 12);
    check("mid_rst_irq_late", {31'b0, irq}, 32'd0);
    run(32'd2, 32'd3, 32'h3, 32'd8, 32'h1, "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
